// File: rtl/matmul_ctrl.sv
// Matrix multiply controller: walks C = A x B one element at a time,
// reading A/B from an external memory, accumulating K products and
// writing each finished C element back before moving to the next one.
module matmul_ctrl #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      start,
  input  logic                                      stop,
  output logic                                      busy,
  output logic                                      done,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]         data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]         data_in_b,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0]      row_addr_a,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0]      col_addr_a,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0]      row_addr_b,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]      col_addr_b,
  output logic                                      matrix_a_re,
  output logic                                      matrix_b_re,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0]      row_addr_c,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]      col_addr_c,
  output logic                                      matrix_c_we,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0]       data_out_c
);

  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int RW = DATA_WIDTH_RESULT_MATRIX;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [MW-1:0]   i;
  logic [KW-1:0]   k;
  logic [NW-1:0]   j;
  logic [RW-1:0]   acc;
  logic [2*DW-1:0] product;
  logic            last_element;

  assign product      = {{DW{1'b0}}, data_in_a} * {{DW{1'b0}}, data_in_b};
  assign last_element = (i == M_LAST) && (j == N_LAST);

  // State register; reset parks the controller in IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decision: stop aborts MAC/WRITE, DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && !stop) state_next = MAC;
      MAC: begin
        if (stop)             state_next = IDLE;
        else if (k == K_LAST) state_next = WRITE;
      end
      WRITE: begin
        if (stop)              state_next = IDLE;
        else if (last_element) state_next = DONE;
        else                   state_next = MAC;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Index and accumulator updates; an abort clears everything for the next run.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          if (stop) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end else begin
            acc <= acc + RW'(product);
            k   <= (k == K_LAST) ? '0 : k + KW'(1);
          end
        end
        WRITE: begin
          acc <= '0;
          if (stop || last_element) begin
            i <= '0;
            j <= '0;
          end else if (j != N_LAST) begin
            j <= j + NW'(1);
          end else begin
            j <= '0;
            i <= i + MW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs are decoded from the state and held at zero elsewhere.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    row_addr_a  = '0;
    col_addr_a  = '0;
    row_addr_b  = '0;
    col_addr_b  = '0;
    matrix_a_re = 1'b0;
    matrix_b_re = 1'b0;
    row_addr_c  = '0;
    col_addr_c  = '0;
    matrix_c_we = 1'b0;
    data_out_c  = '0;
    case (state)
      MAC: begin
        busy        = 1'b1;
        row_addr_a  = i;
        col_addr_a  = k;
        row_addr_b  = k;
        col_addr_b  = j;
        matrix_a_re = 1'b1;
        matrix_b_re = 1'b1;
      end
      WRITE: begin
        busy        = 1'b1;
        row_addr_c  = i;
        col_addr_c  = j;
        matrix_c_we = 1'b1;
        data_out_c  = acc;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl (2x2x2, 8-bit elements): directed scenarios plus
// randomized start/stop/reset traffic checked cycle by cycle against a
// timeline model of the run and against the mathematical product.
module tb_matmul_ctrl;

  localparam int M    = 2;
  localparam int K    = 2;
  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int RW   = 17;
  localparam int BUSY = M*N*(K+1);

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic          busy, done;
  logic [DW-1:0] data_in_a, data_in_b;
  logic [0:0]    row_addr_a, col_addr_a, row_addr_b, col_addr_b;
  logic [0:0]    row_addr_c, col_addr_c;
  logic          matrix_a_re, matrix_b_re, matrix_c_we;
  logic [RW-1:0] data_out_c;

  logic [DW-1:0] a_mem [M][K];
  logic [DW-1:0] b_mem [K][N];
  logic [RW-1:0] c_mem [M][N];
  logic [RW-1:0] exp_c [M][N];

  int total = 0;
  int bad   = 0;
  int t     = 0;
  bit checking = 1'b0;
  int writes_seen = 0;
  int dones_seen  = 0;
  int wlog [$];

  matmul_ctrl #(
    .M(M), .K(K), .N(N),
    .DATA_WIDTH_INIT_MATRIX(DW),
    .DATA_WIDTH_RESULT_MATRIX(RW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .busy(busy), .done(done),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
    .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
    .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re),
    .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
    .matrix_c_we(matrix_c_we), .data_out_c(data_out_c)
  );

  always #5 clk = ~clk;

  assign data_in_a = a_mem[row_addr_a][col_addr_a];
  assign data_in_b = b_mem[row_addr_b][col_addr_b];

  // External C memory: commits whatever the controller writes.
  always @(posedge clk) begin
    if (matrix_c_we) c_mem[row_addr_c][col_addr_c] <= data_out_c;
  end

  function automatic int dot(int r, int c);
    int s = 0;
    for (int q = 0; q < K; q++) s += int'(a_mem[r][q]) * int'(b_mem[q][c]);
    return s;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(bit s_start, bit s_stop);
    start = s_start;
    stop  = s_stop;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(string name);
    for (int n = 0; n < 60 && (busy || done); n++) applyStimulus(1'b0, 1'b0);
    checkOutput(name, int'(busy | done), 0);
  endtask

  // Run timeline: t=0 idle, t=1..BUSY busy cycles, t=BUSY+1 the done cycle.
  always @(posedge clk) begin
    int e, p;
    if (t >= 1 && t <= BUSY) begin
      e = (t - 1) / (K + 1);
      p = (t - 1) % (K + 1);
      if (p == K) exp_c[e / N][e % N] = RW'(dot(e / N, e % N));
    end
    if (!resetn)                 t = 0;
    else if (t == 0)             t = (start && !stop) ? 1 : 0;
    else if (t == BUSY + 1)      t = 0;
    else if (stop)               t = 0;
    else                         t = t + 1;
  end

  // Cycle-by-cycle comparison of every output against the timeline.
  always @(negedge clk) begin
    int e, p, ei, ej;
    int x_busy, x_done, x_re, x_we, x_ra, x_ca, x_rb, x_cb, x_rc, x_cc, x_dat;
    if (checking) begin
      x_busy = 0; x_done = 0; x_re = 0; x_we = 0;
      x_ra = 0; x_ca = 0; x_rb = 0; x_cb = 0; x_rc = 0; x_cc = 0; x_dat = 0;
      if (t >= 1 && t <= BUSY) begin
        e  = (t - 1) / (K + 1);
        p  = (t - 1) % (K + 1);
        ei = e / N;
        ej = e % N;
        x_busy = 1;
        if (p < K) begin
          x_re = 1; x_ra = ei; x_ca = p; x_rb = p; x_cb = ej;
        end else begin
          x_we = 1; x_rc = ei; x_cc = ej; x_dat = dot(ei, ej);
        end
      end else if (t == BUSY + 1) begin
        x_done = 1;
      end
      checkOutput("busy", int'(busy), x_busy);
      checkOutput("done", int'(done), x_done);
      checkOutput("a_re", int'(matrix_a_re), x_re);
      checkOutput("b_re", int'(matrix_b_re), x_re);
      checkOutput("row_addr_a", int'(row_addr_a), x_ra);
      checkOutput("col_addr_a", int'(col_addr_a), x_ca);
      checkOutput("row_addr_b", int'(row_addr_b), x_rb);
      checkOutput("col_addr_b", int'(col_addr_b), x_cb);
      checkOutput("c_we", int'(matrix_c_we), x_we);
      checkOutput("row_addr_c", int'(row_addr_c), x_rc);
      checkOutput("col_addr_c", int'(col_addr_c), x_cc);
      checkOutput("data_out_c", int'(data_out_c), x_dat);
      if (matrix_c_we) begin
        writes_seen++;
        wlog.push_back(int'(row_addr_c) * N + int'(col_addr_c));
      end
      if (done) dones_seen++;
    end
  end

  initial begin
    int wb, db, lb, done_cycle, busy_cnt;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        c_mem[r][c] = '0;
        exp_c[r][c] = '0;
      end
    a_mem[0][0] = 8'd1; a_mem[0][1] = 8'd0; a_mem[1][0] = 8'd0; a_mem[1][1] = 8'd1;
    b_mem[0][0] = 8'd1; b_mem[0][1] = 8'd2; b_mem[1][0] = 8'd3; b_mem[1][1] = 8'd4;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_we", int'(matrix_c_we), 0);

    // Identity x {{1,2},{3,4}}, started on the first edge out of reset.
    resetn = 1'b1;
    wb = writes_seen; db = dones_seen; lb = wlog.size();
    done_cycle = 0; busy_cnt = 0;
    applyStimulus(1'b1, 1'b0);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) done_cycle = c;
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
    checkOutput("id_done_cycle", done_cycle, 13);
    checkOutput("id_busy_cycles", busy_cnt, 12);
    checkOutput("id_writes", writes_seen - wb, 4);
    checkOutput("id_dones", dones_seen - db, 1);
    for (int n = 0; n < 4; n++) checkOutput("id_order", (wlog.size() > lb + n) ? wlog[lb + n] : -1, n);
    checkOutput("id_c00", int'(c_mem[0][0]), 1);
    checkOutput("id_c01", int'(c_mem[0][1]), 2);
    checkOutput("id_c10", int'(c_mem[1][0]), 3);
    checkOutput("id_c11", int'(c_mem[1][1]), 4);

    // All-255 operands reach the full result width.
    waitIdle("idle_before_max");
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        a_mem[r][c] = 8'hFF;
        b_mem[r][c] = 8'hFF;
      end
    wb = writes_seen;
    applyStimulus(1'b1, 1'b0);
    repeat (15) applyStimulus(1'b0, 1'b0);
    checkOutput("max_writes", writes_seen - wb, 4);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) checkOutput("max_value", int'(c_mem[r][c]), 130050);

    // Stop in the second MAC cycle of element (0,1).
    a_mem[0][0] = 8'd1; a_mem[0][1] = 8'd2; a_mem[1][0] = 8'd3; a_mem[1][1] = 8'd4;
    b_mem[0][0] = 8'd5; b_mem[0][1] = 8'd6; b_mem[1][0] = 8'd7; b_mem[1][1] = 8'd8;
    wb = writes_seen; db = dones_seen;
    applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_idle", int'(busy), 0);
    repeat (15) applyStimulus(1'b0, 1'b0);
    checkOutput("abort_writes", writes_seen - wb, 1);
    checkOutput("abort_dones", dones_seen - db, 0);
    checkOutput("abort_c00", int'(c_mem[0][0]), 19);
    checkOutput("abort_c01_kept", int'(c_mem[0][1]), 130050);

    // Start re-pulsed during cycles 3 and 12 of a run is ignored.
    wb = writes_seen; db = dones_seen;
    applyStimulus(1'b1, 1'b0);
    for (int c = 1; c <= 20; c++) applyStimulus((c == 3) || (c == 12), 1'b0);
    checkOutput("repulse_writes", writes_seen - wb, 4);
    checkOutput("repulse_dones", dones_seen - db, 1);

    // Reset during MAC of element (1,0), then a clean full run.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        a_mem[r][c] = DW'($urandom_range(0, 255));
        b_mem[r][c] = DW'($urandom_range(0, 255));
      end
    applyStimulus(1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0);
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_re", int'(matrix_a_re), 0);
    resetn = 1'b1;
    wb = writes_seen;
    applyStimulus(1'b1, 1'b0);
    repeat (15) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_rerun_writes", writes_seen - wb, 4);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) checkOutput("rst_rerun_c", int'(c_mem[r][c]), dot(r, c));

    // Start and stop together in IDLE do nothing.
    applyStimulus(1'b1, 1'b1);
    checkOutput("startstop_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("startstop_busy2", int'(busy), 0);

    // Randomized start/stop/reset traffic over fresh matrices.
    for (int run = 0; run < 30; run++) begin
      waitIdle("idle_before_random");
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          a_mem[r][c] = (run % 7 == 0) ? 8'hFF : DW'($urandom_range(0, 255));
          b_mem[r][c] = (run % 7 == 0) ? 8'hFF : DW'($urandom_range(0, 255));
        end
      for (int c = 0; c < 30; c++) begin
        resetn = ($urandom_range(0, 59) != 0);
        applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      end
      resetn = 1'b1;
      applyStimulus(1'b0, 1'b0);
    end
    waitIdle("idle_final");
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) checkOutput("mem_final", int'(c_mem[r][c]), int'(exp_c[r][c]));

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
